// File: rtl/fc_layer_ctrl_pkg.sv
// Shared types and widths for the fully-connected layer controller.
// The activation and weight memories are external to this block.
package fc_layer_ctrl_pkg;

  localparam int DATA_W     = 8;
  localparam int PROD_W     = 16;
  localparam int ACC_W      = 20;
  localparam int IN_ADDR_W  = 10;
  localparam int W_ADDR_W   = 15;
  localparam int OUT_ADDR_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Negative results become zero when the ReLU clamp is enabled.
  function automatic logic [ACC_W-1:0] relu_clamp(input logic [ACC_W-1:0] v, input logic en);
    return (en && v[ACC_W-1]) ? '0 : v;
  endfunction

endpackage

// File: rtl/fc_layer_ctrl_if.sv
// Control, memory-read and result-write signals of the layer controller.
// The master modport is the controller; slave is the host/memory side.
interface fc_layer_ctrl_if;
  import fc_layer_ctrl_pkg::*;

  logic                         start;
  logic                         abort;
  logic                         busy;
  logic                         done;
  logic        [IN_ADDR_W-1:0]  in_addr;
  logic        [W_ADDR_W-1:0]   w_addr;
  logic signed [DATA_W-1:0]     in_data;
  logic signed [DATA_W-1:0]     w_data;
  logic                         out_we;
  logic        [OUT_ADDR_W-1:0] out_addr;
  logic        [ACC_W-1:0]      out_data;

  modport master (
    input  start, abort, in_data, w_data,
    output busy, done, in_addr, w_addr, out_we, out_addr, out_data
  );

  modport slave (
    output start, abort, in_data, w_data,
    input  busy, done, in_addr, w_addr, out_we, out_addr, out_data
  );

endinterface

// File: rtl/fc_layer_ctrl_mac_unit.sv
// Signed 8x8 multiply-accumulate with a 20-bit wrapping accumulator.
// clr has priority over en so a fresh neuron always starts from zero.
module mac_unit
  import fc_layer_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [PROD_W-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end
  end

endmodule

// File: rtl/fc_layer_ctrl.sv
// Sequences one dense-layer pass: per neuron, clear, stream N_IN products
// through the MAC (one-cycle memory latency), then write the result.
module fc_layer_ctrl
  import fc_layer_ctrl_pkg::*;
#(
  parameter int N_IN  = 784,
  parameter int N_OUT = 32,
  parameter int RELU  = 1
) (
  input  logic            clk,
  input  logic            rst,
  fc_layer_ctrl_if.master bus
);

  localparam logic [IN_ADDR_W-1:0]  LAST_I = IN_ADDR_W'(N_IN - 1);
  localparam logic [OUT_ADDR_W-1:0] LAST_N = OUT_ADDR_W'(N_OUT - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [IN_ADDR_W-1:0]    idx;
  logic [OUT_ADDR_W-1:0]   neuron;
  logic [W_ADDR_W-1:0]     w_cnt;
  logic                    mac_en;
  logic                    mac_clr;
  logic signed [ACC_W-1:0] acc;
  logic                    active;

  assign active = (state != ST_IDLE) && (state != ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // mac_en trails the address by one cycle: the first RUN cycle has no data
  // yet, and DRAIN consumes the data of the last issued address.
  always_comb begin
    state_nxt = state;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    case (state)
      ST_IDLE:  if (bus.start && !bus.abort) state_nxt = ST_CLR;
      ST_CLR: begin
        mac_clr   = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        mac_en = (idx != '0);
        if (idx == LAST_I) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        mac_en    = 1'b1;
        state_nxt = ST_WRITE;
      end
      ST_WRITE: state_nxt = (neuron == LAST_N) ? ST_DONE : ST_CLR;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (bus.abort && active) state_nxt = ST_IDLE;
  end

  // The weight address is a running counter, so neuron*N_IN never needs a multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      neuron <= '0;
      w_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (state_nxt == ST_CLR) begin
            idx    <= '0;
            neuron <= '0;
            w_cnt  <= '0;
          end
        end
        ST_CLR: idx <= '0;
        ST_RUN: begin
          idx   <= idx + 1'b1;
          w_cnt <= w_cnt + 1'b1;
        end
        ST_WRITE: if (neuron != LAST_N) neuron <= neuron + 1'b1;
        default: ;
      endcase
    end
  end

  mac_unit u_mac (
    .clk (clk),
    .rst (rst),
    .en  (mac_en),
    .clr (mac_clr),
    .a   (bus.in_data),
    .b   (bus.w_data),
    .acc (acc)
  );

  assign bus.busy     = active;
  assign bus.done     = (state == ST_DONE);
  assign bus.in_addr  = idx;
  assign bus.w_addr   = w_cnt;
  assign bus.out_we   = (state == ST_WRITE);
  assign bus.out_addr = neuron;
  assign bus.out_data = bus.out_we ? relu_clamp(acc, RELU != 0) : '0;

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Bench for fc_layer_ctrl (N_IN=4, N_OUT=2): one RELU=1 and one RELU=0 instance,
// expected writes queued at stimulus time and popped by a negedge monitor.
module tb_fc_layer_ctrl;
  import fc_layer_ctrl_pkg::*;

  typedef struct packed {
    logic [OUT_ADDR_W-1:0] addr;
    logic [ACC_W-1:0]      data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fc_layer_ctrl_if bus_r ();
  fc_layer_ctrl_if bus_l ();

  fc_layer_ctrl #(.N_IN(4), .N_OUT(2), .RELU(1)) dut_r (.clk(clk), .rst(rst), .bus(bus_r));
  fc_layer_ctrl #(.N_IN(4), .N_OUT(2), .RELU(0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

  logic signed [7:0] act [4];
  logic signed [7:0] wgt [8];
  wr_t exp_r [$];
  wr_t exp_l [$];
  wr_t er;
  wr_t el;

  int checks     = 0;
  int errors     = 0;
  int edge_cnt   = 0;
  int t0         = 0;
  int done_r     = 0;
  int done_l     = 0;
  int done_cyc_r = -1;
  int done_cyc_l = -1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(posedge clk) edge_cnt++;

  // Memories with one-cycle read latency.
  always @(posedge clk) begin
    bus_r.in_data <= act[bus_r.in_addr[1:0]];
    bus_r.w_data  <= wgt[bus_r.w_addr[2:0]];
    bus_l.in_data <= act[bus_l.in_addr[1:0]];
    bus_l.w_data  <= wgt[bus_l.w_addr[2:0]];
  end

  always @(negedge clk) begin
    if (bus_r.out_we) begin
      if (exp_r.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL relu_write: unexpected write addr %0d data 0x%0h, expected none", bus_r.out_addr, bus_r.out_data);
      end else begin
        er = exp_r.pop_front();
        check_output("relu_out_addr", 32'(bus_r.out_addr), 32'(er.addr));
        check_output("relu_out_data", 32'(bus_r.out_data), 32'(er.data));
      end
    end else begin
      check_output("relu_idle_out_data", 32'(bus_r.out_data), 32'd0);
    end
    if (bus_r.done) begin
      done_r++;
      done_cyc_r = edge_cnt - t0;
    end
    if (bus_l.out_we) begin
      if (exp_l.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL lin_write: unexpected write addr %0d data 0x%0h, expected none", bus_l.out_addr, bus_l.out_data);
      end else begin
        el = exp_l.pop_front();
        check_output("lin_out_addr", 32'(bus_l.out_addr), 32'(el.addr));
        check_output("lin_out_data", 32'(bus_l.out_data), 32'(el.data));
      end
    end else begin
      check_output("lin_idle_out_data", 32'(bus_l.out_data), 32'd0);
    end
    if (bus_l.done) begin
      done_l++;
      done_cyc_l = edge_cnt - t0;
    end
  end

  function automatic int rel();
    return edge_cnt - t0;
  endfunction

  task automatic load_nominal();
    for (int k = 0; k < 4; k++) act[k] = 8'(k + 1);
    for (int k = 0; k < 8; k++) wgt[k] = (k < 4) ? 8'sd1 : -8'sd1;
  endtask

  task automatic push_nominal_r();
    exp_r.push_back('{addr: 5'd0, data: 20'd10});
    exp_r.push_back('{addr: 5'd1, data: 20'd0});
  endtask

  // Pulse start for one cycle; the sampling edge becomes relative edge 0.
  task automatic apply_stimulus(input bit lin);
    @(negedge clk);
    t0 = edge_cnt;
    if (lin) bus_l.start = 1'b1;
    else     bus_r.start = 1'b1;
    @(negedge clk);
    bus_l.start = 1'b0;
    bus_r.start = 1'b0;
  endtask

  task automatic run_until(input int c);
    while (rel() < c) @(negedge clk);
  endtask

  task automatic nominal_pass(input string tag);
    int d0;
    d0 = done_r;
    load_nominal();
    push_nominal_r();
    apply_stimulus(1'b0);
    run_until(3);
    check_output({tag, "_busy_mid"}, 32'(bus_r.busy), 32'd1);
    run_until(20);
    check_output({tag, "_done_count"}, 32'(done_r - d0), 32'd1);
    check_output({tag, "_done_cycle"}, 32'(done_cyc_r), 32'd15);
    check_output({tag, "_writes_pending"}, 32'(exp_r.size()), 32'd0);
  endtask

  initial begin
    int d0;
    bus_r.start = 1'b0;
    bus_r.abort = 1'b0;
    bus_l.start = 1'b0;
    bus_l.abort = 1'b0;
    load_nominal();

    repeat (3) @(negedge clk);
    check_output("reset_busy", 32'(bus_r.busy), 32'd0);
    check_output("reset_done", 32'(bus_r.done), 32'd0);
    check_output("reset_w_addr", 32'(bus_r.w_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_output("idle_busy", 32'(bus_r.busy), 32'd0);

    nominal_pass("nominal");

    // RELU disabled: negative result passes through, w_addr walks 0..7 in RUN.
    d0 = done_l;
    exp_l.push_back('{addr: 5'd0, data: 20'd10});
    exp_l.push_back('{addr: 5'd1, data: 20'hFFFF6});
    apply_stimulus(1'b1);
    while (rel() <= 20) begin
      if (rel() >= 2 && rel() <= 5)  check_output("lin_w_addr", 32'(bus_l.w_addr), 32'(rel() - 2));
      if (rel() >= 9 && rel() <= 12) check_output("lin_w_addr", 32'(bus_l.w_addr), 32'(rel() - 5));
      @(negedge clk);
    end
    check_output("lin_done_count", 32'(done_l - d0), 32'd1);
    check_output("lin_done_cycle", 32'(done_cyc_l), 32'd15);
    check_output("lin_writes_pending", 32'(exp_l.size()), 32'd0);

    // Full scale: (-128)*(-128)*4 = 65536 per neuron.
    d0 = done_r;
    for (int k = 0; k < 4; k++) act[k] = -8'sd128;
    for (int k = 0; k < 8; k++) wgt[k] = -8'sd128;
    exp_r.push_back('{addr: 5'd0, data: 20'd65536});
    exp_r.push_back('{addr: 5'd1, data: 20'd65536});
    apply_stimulus(1'b0);
    run_until(20);
    check_output("full_done_count", 32'(done_r - d0), 32'd1);
    check_output("full_writes_pending", 32'(exp_r.size()), 32'd0);

    // start while busy (cycle 5) and while in DONE (cycle 15) is ignored.
    d0 = done_r;
    load_nominal();
    push_nominal_r();
    apply_stimulus(1'b0);
    run_until(5);
    bus_r.start = 1'b1;
    @(negedge clk);
    bus_r.start = 1'b0;
    run_until(15);
    bus_r.start = 1'b1;
    @(negedge clk);
    bus_r.start = 1'b0;
    run_until(35);
    check_output("busy_start_done_count", 32'(done_r - d0), 32'd1);
    check_output("busy_start_writes_pending", 32'(exp_r.size()), 32'd0);

    // abort in cycle 4: idle next cycle, no write, no done.
    d0 = done_r;
    apply_stimulus(1'b0);
    run_until(4);
    bus_r.abort = 1'b1;
    @(negedge clk);
    bus_r.abort = 1'b0;
    check_output("abort_busy", 32'(bus_r.busy), 32'd0);
    run_until(20);
    check_output("abort_done_count", 32'(done_r - d0), 32'd0);

    // abort wins over start in IDLE.
    bus_r.start = 1'b1;
    bus_r.abort = 1'b1;
    @(negedge clk);
    bus_r.start = 1'b0;
    bus_r.abort = 1'b0;
    check_output("abort_start_busy", 32'(bus_r.busy), 32'd0);
    @(negedge clk);
    check_output("abort_start_busy2", 32'(bus_r.busy), 32'd0);
    check_output("abort_start_done_count", 32'(done_r - d0), 32'd0);
    nominal_pass("after_abort");

    // rst during neuron 1 RUN: only neuron 0 was written.
    d0 = done_r;
    exp_r.push_back('{addr: 5'd0, data: 20'd10});
    apply_stimulus(1'b0);
    run_until(9);
    #2 rst = 1'b1;
    #1;
    check_output("rst_busy", 32'(bus_r.busy), 32'd0);
    check_output("rst_done", 32'(bus_r.done), 32'd0);
    check_output("rst_out_we", 32'(bus_r.out_we), 32'd0);
    check_output("rst_in_addr", 32'(bus_r.in_addr), 32'd0);
    check_output("rst_w_addr", 32'(bus_r.w_addr), 32'd0);
    check_output("rst_out_addr", 32'(bus_r.out_addr), 32'd0);
    check_output("rst_out_data", 32'(bus_r.out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_until(25);
    check_output("rst_no_resume_busy", 32'(bus_r.busy), 32'd0);
    check_output("rst_done_count", 32'(done_r - d0), 32'd0);
    check_output("rst_writes_pending", 32'(exp_r.size()), 32'd0);
    nominal_pass("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fc_layer_ctrl.md
FC_LAYER_CTRL -- requirements
Module: fc_layer_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- N_IN, 784, inputs per neuron (dot-product length), range 1..1024.
- N_OUT, 32, neurons in the layer, range 1..32.
- RELU, 1, 1 = clamp negative results to 0; 0 = pass the signed result.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse that starts one layer pass; sampled only in IDLE.
- abort  in  1  synchronous cancel of the current pass.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle pulse when the pass completes.
- in_addr  out  10  activation memory read address.
- w_addr  out  15  weight memory read address, row-major: neuron*N_IN + i.
- in_data  in  8  signed activation, valid one cycle after in_addr.
- w_data  in  8  signed weight, valid one cycle after w_addr.
- out_we  out  1  result write strobe.
- out_addr  out  5  result neuron index.
- out_data  out  20  signed result; forced to 0 whenever out_we = 0.

Function
REQ-003 The FSM SHALL use states IDLE, CLR, RUN, DRAIN, WRITE, DONE.
- IDLE->CLR on start; CLR->RUN; RUN->DRAIN after the address i = N_IN-1 is issued; DRAIN->WRITE.
- WRITE->CLR if neuron < N_OUT-1, else WRITE->DONE; DONE->IDLE.
REQ-004 In CLR the block SHALL assert mac_clr for exactly one cycle and reset the input index i to 0.
REQ-005 In RUN the block SHALL issue in_addr = i and w_addr = neuron*N_IN + i, advancing i by one each cycle.
- w_addr SHALL come from a running counter (no multiplier); it is held across CLR, DRAIN and WRITE and reset to 0 only at pass start.
REQ-006 Memory reads have a fixed one-cycle latency, so the block SHALL assert mac_en exactly one cycle after each issued address.
- mac_en SHALL be high in RUN cycles 2..N_IN and in DRAIN.
- Each neuron receives exactly N_IN accumulates.
REQ-007 In WRITE the block SHALL drive:
- out_we = 1 for one cycle;
- out_addr = neuron;
- out_data = accumulator, or 0 when RELU = 1 and the accumulator is negative.
REQ-008 Per-neuron time SHALL be N_IN+3 cycles.
- If start is sampled at edge 0, done SHALL be high in cycle N_OUT*(N_IN+3)+1.
REQ-009 Arithmetic: each product is 16-bit signed, sign-extended to 20 bits and accumulated modulo 2^20 (two's-complement wrap, no saturation).
- The overflow-free limit is N_IN <= 31 with full-scale inputs.
REQ-010 Boundary conditions:
- start while busy or in DONE SHALL be ignored.
- N_IN = 1 SHALL give RUN of one cycle.
- N_OUT = 1 SHALL go WRITE->DONE directly.
REQ-011 abort while busy SHALL force IDLE on the next edge with out_we = 0 and no done pulse; abort in IDLE has no effect.
- If abort and start are both high in IDLE, abort SHALL win.

Reset
REQ-012 rst SHALL asynchronously force all of the following; deasserting rst mid-pass SHALL never resume the pass:
- state = IDLE;
- busy, done, out_we, mac_en, mac_clr = 0;
- in_addr, w_addr, out_addr, out_data = 0;
- internal counters = 0.
REQ-013 The accumulator SHALL be cleared by CLR before every neuron, so no result depends on accumulator reset timing.

Structure
REQ-014 A shared package SHALL hold:
- the state encoding;
- the data widths (8, 16, 20);
- the address widths (10, 15, 5).
REQ-015 fc_layer_ctrl SHALL instantiate exactly one sub-module, mac_unit, driven by:
- en = mac_en, clr = mac_clr;
- a = in_data, b = w_data;
- rst.

Verification
REQ-016 The bench SHALL use N_IN = 4, N_OUT = 2 and activations [1,2,3,4] unless stated otherwise, and SHALL cover:
- Nominal: weights n0 = [1,1,1,1], n1 = [-1,-1,-1,-1], RELU = 1 -> writes (0, 10) and (1, 0); done in cycle 15.
- RELU = 0, same data -> writes (0, 10) and (1, -10); w_addr sequence 0..7.
- Full scale: all activations and weights = -128 -> each result 65536; out_data = 0 whenever out_we = 0.
- start pulsed in cycle 5 while busy -> ignored; exactly two writes and one done.
- abort in cycle 4 -> IDLE next cycle, no write, no done; a fresh start then gives the nominal results.
- rst asserted in cycle 9 (neuron 1 RUN) -> all outputs 0 immediately, state IDLE; a restart gives the nominal results.
